// File: rtl/alu_op_sequencer.sv
// Byte-stream front-end for the 4-bit ALU: loads operands, then an opcode, drives the ALU
// with stable registered inputs, captures its result and returns it over valid/ready.
module alu_op_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_sel,
    input  logic [7:0]       alu_result,
    output logic [7:0]       res_data,
    output logic             res_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] op_count,
    output logic             timeout_err,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_OP = 3'd1,
        S_EXEC    = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    localparam int TMR_W = $clog2(TIMEOUT);

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic               din_xfer;
    logic               res_xfer;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holds its data while ready is low, and ready/valid alone have no effect.
    assign din_ready = ~rst & ((state == S_IDLE) | (state == S_WAIT_OP));
    assign din_xfer  = din_valid & din_ready;
    assign res_xfer  = res_valid & res_ready;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= '0;
            res_data    <= '0;
            res_zero    <= 1'b1;
            res_valid   <= 1'b0;
            op_count    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (din_xfer) begin
                        alu_a <= din[3:0];
                        alu_b <= din[7:4];
                        timer <= '0;
                        state <= S_WAIT_OP;
                    end
                end
                S_WAIT_OP: begin
                    // An opcode arriving on the final allowed cycle still beats the abort.
                    if (din_xfer) begin
                        alu_sel <= din[1:0];
                        state   <= S_EXEC;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_EXEC: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    res_data  <= alu_result;
                    res_zero  <= (alu_result == 8'd0);
                    res_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_xfer) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
